// File: rtl/mor1kx_ibus_wb_espresso_if.sv
// Wishbone B3 classic bus bundle between the espresso instruction fetch
// bridge (master) and the memory system (slave).
`timescale 1ns/1ps
interface mor1kx_ibus_wb_espresso_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] dat;
  logic             cyc;
  logic             stb;
  logic             we;
  logic [3:0]       sel;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;
  logic             err;
  logic             rty;

  modport master (
    output adr, cyc, stb, we, sel, cti, bte,
    input  dat, ack, err, rty
  );

  modport slave (
    input  adr, cyc, stb, we, sel, cti, bte,
    output dat, ack, err, rty
  );
endinterface

// File: rtl/mor1kx_ibus_wb_espresso.sv
// Single-outstanding instruction fetch bridge from the espresso fetch unit to
// Wishbone classic, with abort-by-drain and an optional bus timeout.
`timescale 1ns/1ps
module mor1kx_ibus_wb_espresso #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_IBUS_TIMEOUT  = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cpu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] cpu_adr_i,
  output logic                            cpu_ack_o,
  output logic                            cpu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] cpu_dat_o,
  mor1kx_ibus_wb_espresso_if.master       wbm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [OPTION_OPERAND_WIDTH-1:0] NOP_INSN = OPTION_OPERAND_WIDTH'(32'h1500_0000);
  localparam logic [7:0] TIMEOUT    = 8'(OPTION_IBUS_TIMEOUT);
  localparam bit         TIMEOUT_EN = (OPTION_IBUS_TIMEOUT != 0);

  logic [1:0]                      state;
  logic [7:0]                      cnt;
  logic                            cyc_q;
  logic [OPTION_OPERAND_WIDTH-1:0] adr_q;

  logic       term;
  logic       still_wanted;
  logic [7:0] cnt_next;
  logic       timeout_hit;

  assign term         = wbm.ack | wbm.err | wbm.rty;
  // The fetch unit may redirect while a read is open; only the address it
  // still asks for may produce a response.
  assign still_wanted = cpu_req_i && (cpu_adr_i == adr_q);
  assign cnt_next     = (cnt == 8'hff) ? cnt : cnt + 8'd1;
  assign timeout_hit  = TIMEOUT_EN && (cnt_next >= TIMEOUT);

  assign wbm.adr = adr_q;
  assign wbm.cyc = cyc_q;
  assign wbm.stb = cyc_q;
  assign wbm.we  = 1'b0;
  assign wbm.sel = 4'hf;
  assign wbm.cti = 3'b000;
  assign wbm.bte = 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cyc_q     <= 1'b0;
      adr_q     <= '0;
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
      cpu_dat_o <= NOP_INSN;
    end else begin
      // NOTE: non-blocking defaults here make ack/err single-cycle pulses;
      // a later assignment in the same block overrides them for this edge.
      cpu_ack_o <= 1'b0;
      cpu_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req_i) begin
            adr_q <= cpu_adr_i;
            cnt   <= '0;
            cyc_q <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          cnt <= cnt_next;
          if (term) begin
            cyc_q <= 1'b0;
            state <= IDLE;
            if (still_wanted) begin
              if (wbm.err) begin
                cpu_err_o <= 1'b1;
                state     <= RESP;
              end else if (wbm.ack) begin
                cpu_ack_o <= 1'b1;
                cpu_dat_o <= wbm.dat;
                state     <= RESP;
              end
            end
          end else if (timeout_hit) begin
            cyc_q     <= 1'b0;
            cpu_err_o <= 1'b1;
            state     <= RESP;
          end else if (!still_wanted) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          cnt <= cnt_next;
          if (term || timeout_hit) begin
            cyc_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mor1kx_ibus_wb_espresso.sv
// Self-checking bench for mor1kx_ibus_wb_espresso: directed cases plus random
// fetches scored against a transaction-level latency/response model.
`timescale 1ns/1ps
module tb_mor1kx_ibus_wb_espresso;

  localparam int W = 32;
  localparam int T = 4;
  localparam logic [31:0] NOP = 32'h1500_0000;

  typedef enum int {K_ACK, K_ERR, K_RTY} kind_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cpu_req, cpu_ack, cpu_err;
  logic [W-1:0]  cpu_adr, cpu_dat;
  logic          nt_req, nt_ack, nt_err;
  logic [W-1:0]  nt_adr, nt_dat;

  mor1kx_ibus_wb_espresso_if #(.WIDTH(W)) wb ();
  mor1kx_ibus_wb_espresso_if #(.WIDTH(W)) wb_nt ();

  mor1kx_ibus_wb_espresso #(.OPTION_OPERAND_WIDTH(W), .OPTION_IBUS_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_adr_i(cpu_adr),
    .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_dat_o(cpu_dat), .wbm(wb)
  );

  mor1kx_ibus_wb_espresso #(.OPTION_OPERAND_WIDTH(W), .OPTION_IBUS_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .cpu_req_i(nt_req), .cpu_adr_i(nt_adr),
    .cpu_ack_o(nt_ack), .cpu_err_o(nt_err), .cpu_dat_o(nt_dat), .wbm(wb_nt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_dat;
  logic        nt_resp_seen;

  always @(negedge clk or posedge rst)
    if (rst) nt_resp_seen = 1'b0;
    else if (nt_ack || nt_err) nt_resp_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_slave();
    wb.ack = 1'b0;
    wb.err = 1'b0;
    wb.rty = 1'b0;
  endtask

  // One fetch starting in IDLE. The slave terminates on the (w+1)-th strobe
  // cycle; a retry is followed by a zero-wait ack on the reissued cycle.
  // Response is expected one cycle after the terminating or timing-out edge.
  task automatic fetch(input logic [31:0] adr, input int w, input kind_t kind,
                       input logic [31:0] data);
    int   exp_lat, lat, n, stb_cnt;
    bit   retried, seen, exp_ack;
    logic got_ack, got_err;
    if (w + 1 > T) begin
      exp_lat = T + 1;
      exp_ack = 1'b0;
    end else if (kind == K_RTY) begin
      exp_lat = w + 4;
      exp_ack = 1'b1;
    end else begin
      exp_lat = w + 2;
      exp_ack = (kind == K_ACK);
    end
    n = 0; lat = 0; stb_cnt = 0; retried = 0; seen = 0;
    got_ack = 1'b0; got_err = 1'b0;
    cpu_req = 1'b1;
    cpu_adr = adr;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack || cpu_err) begin
        seen = 1; lat = n; got_ack = cpu_ack; got_err = cpu_err;
      end
      clear_slave();
      wb.dat = $urandom;
      if (!seen && wb.cyc) begin
        stb_cnt++;
        if (stb_cnt == (retried ? 1 : w + 1)) begin
          if (kind == K_RTY && !retried) begin
            wb.rty = 1'b1; retried = 1; stb_cnt = 0;
          end else if (kind == K_ERR) begin
            wb.err = 1'b1; wb.ack = 1'b1; wb.dat = data;
          end else begin
            wb.ack = 1'b1; wb.dat = data;
          end
        end
      end
    end
    check("resp_seen", 32'(seen), 32'd1);
    check("resp_latency", lat, exp_lat);
    check("cpu_ack", 32'(got_ack), 32'(exp_ack));
    check("cpu_err", 32'(got_err), 32'(!exp_ack));
    check("cyc_in_resp", 32'(wb.cyc), 32'd0);
    if (exp_ack) exp_dat = data;
    check("cpu_dat", cpu_dat, exp_dat);
    cpu_req = 1'b0;
    @(negedge clk);
    check("pulse_end", {30'd0, cpu_ack, cpu_err}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_adr = '0;
    nt_req = 1'b1;  nt_adr = 32'h400;
    clear_slave(); wb.dat = '0;
    wb_nt.ack = 1'b0; wb_nt.err = 1'b0; wb_nt.rty = 1'b0; wb_nt.dat = '0;
    exp_dat = NOP;
    repeat (2) @(negedge clk);
    check("rst_cyc", 32'(wb.cyc), 32'd0);
    check("rst_stb", 32'(wb.stb), 32'd0);
    check("rst_adr", wb.adr, 32'd0);
    check("rst_ack_err", {30'd0, cpu_ack, cpu_err}, 32'd0);
    check("rst_dat", cpu_dat, NOP);
    check("const_bus", {20'd0, wb.we, wb.sel, wb.cti, wb.bte}, {20'd0, 1'b0, 4'hf, 3'b000, 2'b00});
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read, error with simultaneous ack, retry, timeout boundaries.
    fetch(32'h100, 0, K_ACK, 32'hA860_0001);
    fetch(32'h108, 1, K_ERR, 32'hDEAD_BEEF);
    fetch(32'h300, 0, K_RTY, 32'h1234_5678);
    fetch(32'h500, 10, K_ACK, 32'hCAFE_F00D);
    fetch(32'h504, 3, K_ACK, 32'h0BAD_F00D);

    // Branch abort: address moves while the strobe is open.
    cpu_req = 1'b1; cpu_adr = 32'h104;
    @(negedge clk);
    check("abort_cyc_open", 32'(wb.cyc), 32'd1);
    cpu_adr = 32'h200;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("drain_cyc", 32'(wb.cyc & wb.stb), 32'd1);
      check("drain_adr", wb.adr, 32'h104);
      check("drain_no_resp", {30'd0, cpu_ack, cpu_err}, 32'd0);
      if (i == 4) begin wb.ack = 1'b1; wb.dat = 32'hFFFF_0000; end
    end
    @(negedge clk);
    clear_slave();
    check("drain_closed", 32'(wb.cyc), 32'd0);
    check("drain_no_resp2", {30'd0, cpu_ack, cpu_err}, 32'd0);
    check("drain_dat", cpu_dat, exp_dat);
    fetch(32'h200, 1, K_ACK, 32'h9000_0200);

    // A stray ack while idle must be ignored.
    wb.ack = 1'b1; wb.dat = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      check("idle_ack_ignored", {30'd0, cpu_ack, cpu_err}, 32'd0);
    end
    clear_slave();

    for (int k = 0; k < 20; k++) begin
      fetch($urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 5)),
            kind_t'($urandom_range(0, 2)), $urandom);
    end

    // With the timeout disabled the never-answered cycle stays open past saturation.
    repeat (300) @(negedge clk);
    check("nt_cyc_held", 32'(wb_nt.cyc & wb_nt.stb), 32'd1);
    check("nt_no_resp", 32'(nt_resp_seen), 32'd0);

    // Reset in the middle of an open read.
    cpu_req = 1'b1; cpu_adr = 32'h600;
    repeat (2) @(negedge clk);
    check("pre_rst_cyc", 32'(wb.cyc), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cyc", 32'(wb.cyc | wb.stb), 32'd0);
    check("async_rst_dat", cpu_dat, NOP);
    exp_dat = NOP;
    @(negedge clk);
    rst = 1'b0; cpu_req = 1'b0;
    wb.ack = 1'b1; wb.dat = 32'h7777_7777;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_resp", {30'd0, cpu_ack, cpu_err}, 32'd0);
    end
    clear_slave();
    check("post_rst_dat", cpu_dat, exp_dat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
